// File: rtl/game_pkg.sv
// Shared definitions for the terminal game blocks: command codes, round state
// encoding, reaction sentinel values and the 8-bit Galois LFSR step.
package game_pkg;

  localparam logic [10:0] START_CODE     = 11'b00100000000;
  localparam logic [10:0] ABORT_CODE     = 11'b01000000000;

  // Reported for an early press; a real reaction count saturates one below it.
  localparam logic [7:0]  REACT_SENTINEL = 8'hFF;
  localparam logic [7:0]  REACT_SAT      = 8'hFE;

  localparam logic [7:0]  LFSR_SEED      = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0]  LFSR_TAPS      = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT     = 3'd2,
    ST_ALERT    = 3'd3,
    ST_COOLDOWN = 3'd4
  } game_state_e;

  function automatic logic [7:0] lfsr8_step(input logic [7:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR; reloads the seed should it ever reach zero
// so it can never lock up.
module lfsr8 import game_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = lfsr8_step(lfsr_q);
    end
    if (lfsr_d == 8'h00) begin
      lfsr_d = LFSR_SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/danger_reaction_ctrl.sv
// One danger/reaction round: START arms a random delay in ticks, then danger_out
// is raised and the player's response time is measured and reported as hit/miss.
module danger_reaction_ctrl import game_pkg::*; #(
  parameter int unsigned TICK_DIV        = 10_000_000,
  parameter int unsigned MIN_DELAY_TICKS = 10,
  parameter logic [7:0]  DELAY_MASK      = 8'h3F,
  parameter int unsigned TIMEOUT_TICKS   = 30,
  parameter int unsigned COOLDOWN_TICKS  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op_code,
  input  logic        respond,
  output logic        danger_out,
  output logic        busy,
  output logic        result_valid,
  output logic        result_hit,
  output logic [7:0]  reaction_ticks
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    MIN_DELAY = 8'(MIN_DELAY_TICKS);
  localparam logic [7:0]    TIMEOUT   = 8'(TIMEOUT_TICKS);
  localparam logic [7:0]    COOL_LAST = 8'(COOLDOWN_TICKS - 1);

  game_state_e   state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          danger_q, danger_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          hit_q, hit_d;
  logic [7:0]    react_q, react_d;

  logic          tick;
  logic          abort_cmd;
  logic          state_entry;
  logic [7:0]    cnt_inc;
  logic [7:0]    lfsr_val;

  lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .q      (lfsr_val)
  );

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign abort_cmd = (op_code == ABORT_CODE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    hit_d       = hit_q;
    react_d     = react_q;
    // Reaction count including a tick that lands in this very cycle.
    cnt_inc     = cnt_q;
    if (tick && (cnt_q != REACT_SAT)) begin
      cnt_inc = cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (op_code == START_CODE) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = MIN_DELAY + (lfsr_val & DELAY_MASK);
        end
      end
      ST_WAIT: begin
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (respond) begin
          state_d = ST_COOLDOWN;
          valid_d = 1'b1;
          hit_d   = 1'b0;
          react_d = REACT_SENTINEL;
        end else if (tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_d = ST_ALERT;
          end
        end
      end
      ST_ALERT: begin
        // A press on the timeout tick is still a hit, so respond is tested first.
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (respond) begin
          state_d = ST_COOLDOWN;
          valid_d = 1'b1;
          hit_d   = 1'b1;
          react_d = cnt_inc;
        end else if (tick && (cnt_inc == TIMEOUT)) begin
          state_d = ST_COOLDOWN;
          valid_d = 1'b1;
          hit_d   = 1'b0;
          react_d = TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_COOLDOWN: begin
        if (tick) begin
          if (cnt_q >= COOL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    state_entry = (state_d != state_q);
    if (state_entry && (state_d != ST_WAIT)) begin
      cnt_d = 8'd0;
    end

    // Restarting the divider on entry makes the first tick land TICK_DIV cycles in.
    if (state_entry && (state_d inside {ST_WAIT, ST_ALERT, ST_COOLDOWN})) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    danger_d = (state_d == ST_ALERT);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      cnt_q      <= 8'd0;
      danger_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      hit_q      <= 1'b0;
      react_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      danger_q   <= danger_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      hit_q      <= hit_d;
      react_q    <= react_d;
    end
  end

  assign danger_out     = danger_q;
  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign result_hit     = hit_q;
  assign reaction_ticks = react_q;

endmodule

// File: tb/tb_danger_reaction_ctrl.sv
// Randomized rounds (hit, miss, early press, abort, press on the timeout tick,
// reset mid-round) checked every cycle against an edge-timestamp reference model.
module tb_danger_reaction_ctrl;

  localparam int TD       = 4;
  localparam int MIN_DLY  = 10;
  localparam int TIMEOUT  = 30;
  localparam int COOL     = 5;
  localparam logic [10:0] START_OP = 11'h100;
  localparam logic [10:0] ABORT_OP = 11'h200;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_ALERT = 3;
  localparam int P_COOL  = 4;

  localparam int M_HIT    = 0;
  localparam int M_MISS   = 1;
  localparam int M_EARLY  = 2;
  localparam int M_ABORT  = 3;
  localparam int M_TORESP = 4;
  localparam int M_RESET  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] op_code;
  logic        respond;
  logic        danger_out;
  logic        busy;
  logic        result_valid;
  logic        result_hit;
  logic [7:0]  reaction_ticks;

  always #5 clk = ~clk;

  danger_reaction_ctrl #(
    .TICK_DIV        (TD),
    .MIN_DELAY_TICKS (MIN_DLY),
    .DELAY_MASK      (8'h3F),
    .TIMEOUT_TICKS   (TIMEOUT),
    .COOLDOWN_TICKS  (COOL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .op_code        (op_code),
    .respond        (respond),
    .danger_out     (danger_out),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_hit     (result_hit),
    .reaction_ticks (reaction_ticks)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;
  int results = 0;

  // Reference model: phase plus the edge index at which the phase was entered.
  int         m_phase = P_IDLE;
  int         m_t0    = 0;
  int         m_delay = 0;
  logic [7:0] m_lfsr  = 8'hA5;
  logic       m_rv    = 1'b0;
  logic       m_hit   = 1'b0;
  int         m_rt    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_no, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_lfsr_next(input logic [7:0] v);
    logic [7:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 8'b1011_1000;
    return r;
  endfunction

  task automatic model_result(input logic hit, input int rt);
    m_phase = P_COOL;
    m_t0    = edge_no;
    m_rv    = 1'b1;
    m_hit   = hit;
    m_rt    = rt;
    results++;
    $display("[TB] result %0d @edge %0d: hit=%0d reaction_ticks=%0d", results, edge_no, hit, rt);
  endtask

  task automatic model_edge(input logic rst, input logic [10:0] op, input logic resp);
    int k;
    edge_no++;
    m_rv = 1'b0;
    if (rst) begin
      m_phase = P_IDLE;
      m_hit   = 1'b0;
      m_rt    = 0;
      m_lfsr  = 8'hA5;
    end else begin
      case (m_phase)
        P_IDLE: if (op == START_OP) m_phase = P_ARM;
        P_ARM: begin
          if (op == ABORT_OP) begin
            m_phase = P_IDLE;
          end else begin
            m_phase = P_WAIT;
            m_t0    = edge_no;
            m_delay = MIN_DLY + int'(m_lfsr & 8'h3F);
          end
        end
        P_WAIT: begin
          if (op == ABORT_OP) m_phase = P_IDLE;
          else if (resp) model_result(1'b0, 255);
          else if (edge_no == m_t0 + TD * m_delay) begin
            m_phase = P_ALERT;
            m_t0    = edge_no;
          end
        end
        P_ALERT: begin
          k = (edge_no - m_t0) / TD;
          if (op == ABORT_OP) m_phase = P_IDLE;
          else if (resp) model_result(1'b1, (k > 254) ? 254 : k);
          else if (edge_no - m_t0 == TD * TIMEOUT) model_result(1'b0, TIMEOUT);
        end
        P_COOL: if (edge_no == m_t0 + TD * COOL) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
      m_lfsr = ref_lfsr_next(m_lfsr);
    end
  endtask

  task automatic cycle(input logic rst, input logic [10:0] op, input logic resp);
    reset   = rst;
    op_code = op;
    respond = resp;
    @(posedge clk);
    model_edge(rst, op, resp);
    #1;
    check_eq("danger_out", 32'(danger_out), 32'(m_phase == P_ALERT));
    check_eq("busy", 32'(busy), 32'(m_phase != P_IDLE));
    check_eq("result_valid", 32'(result_valid), 32'(m_rv));
    check_eq("result_hit", 32'(result_hit), 32'(m_hit));
    check_eq("reaction_ticks", 32'(reaction_ticks), 32'(m_rt));
  endtask

  initial begin
    int mode;
    int sub;
    int target;
    int last_phase;
    int starts;
    int r;
    int n;
    logic d_rst;
    logic d_resp;
    logic [10:0] d_op;

    reset = 1'b1; op_code = 11'h0; respond = 1'b0;
    mode = M_HIT; sub = 0; target = -1; last_phase = -1; starts = 0;
    repeat (3) cycle(1'b1, 11'h0, 1'b0);

    for (int c = 0; c < 40000 && starts < 48; c++) begin
      n      = edge_no + 1;
      d_rst  = 1'b0;
      d_resp = 1'b0;
      d_op   = 11'($urandom_range(0, 255));

      if (m_phase != last_phase) begin
        last_phase = m_phase;
        target     = -1;
        if (m_phase == P_WAIT &&
            (mode == M_EARLY || mode == M_RESET || (mode == M_ABORT && sub == 1)))
          target = m_t0 + int'($urandom_range(1, 4 * m_delay));
        else if (m_phase == P_ALERT) begin
          if (mode == M_HIT) target = m_t0 + int'($urandom_range(1, TD * TIMEOUT - 1));
          else if (mode == M_TORESP) target = m_t0 + TD * TIMEOUT;
          else if (mode == M_ABORT && sub == 2)
            target = m_t0 + int'($urandom_range(1, TD * TIMEOUT));
        end
      end

      case (m_phase)
        P_IDLE: begin
          r = int'($urandom_range(0, 15));
          if (r < 3) begin
            d_op   = START_OP;
            mode   = int'($urandom_range(0, 5));
            sub    = int'($urandom_range(0, 2));
            starts++;
          end else if (r == 3) d_resp = 1'b1;
          else if (r == 4) d_op = ABORT_OP;
        end
        P_ARM: if (mode == M_ABORT && sub == 0) d_op = ABORT_OP;
        P_COOL: begin
          r = int'($urandom_range(0, 7));
          if (r == 0) d_op = START_OP;
          else if (r == 1) d_op = ABORT_OP;
          else if (r == 2) d_resp = 1'b1;
        end
        default: begin
          if (n == target) begin
            if (mode == M_ABORT) d_op = ABORT_OP;
            else if (mode == M_RESET) d_rst = 1'b1;
            else d_resp = 1'b1;
          end
        end
      endcase

      cycle(d_rst, d_op, d_resp);
    end

    // Let any round in flight finish, with a bounded budget.
    for (int c = 0; c < 1000 && m_phase != P_IDLE; c++) begin
      d_rst  = 1'b0;
      d_resp = 1'b0;
      d_op   = 11'h0;
      if (m_phase != P_COOL && m_phase != P_IDLE && edge_no + 1 == target) d_resp = 1'b1;
      cycle(d_rst, d_op, d_resp);
    end
    check_eq("final_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
